window_feeder: RTL

- Upstream stage of the masked rank-order kernel in the masked 2D filter datapath.
- On start, scans an h×w image stored row-major in pixel memory. For every output pixel (r,c) it streams the n×n neighbourhood, row-major, into the kernel with valid/ready handshaking.
- Out-of-image taps get a padding value and issue no memory read.
- Also reports the output pixel's row/column so the write-back address can be formed downstream.

---
 rtl/window_feeder_pkg.sv | 36 +++
 rtl/window_skid_fifo.sv | 59 +++++
 rtl/window_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/window_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_feeder_pkg
// Summary  : Shared FSM encoding, tap record and sizing helpers for the
//            window feeder and its skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package window_feeder_pkg;

    localparam int c_TAP_WORD       = 32;
    localparam int c_TAP_INPUT_SIZE = 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Default-width layout of one FIFO entry, head of the payload first.
    typedef struct packed {
        logic [c_TAP_INPUT_SIZE-1:0] value;
        logic                        last;
        logic [c_TAP_WORD-1:0]       row;
        logic [c_TAP_WORD-1:0]       col;
    } tap_t;

    // Width needed to hold max_n itself, not just max_n-1.
    function automatic int kernel_n_bits(input int max_n);
        return $clog2(max_n) + 1;
    endfunction

    function automatic int unsigned kernel_off(input int unsigned n);
        return n >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : window_skid_fifo
// Summary  : Two-entry valid/ready FIFO; head entry is held stable until it
//            is popped, and push+pop is accepted while full.
// Revision : 1.0 - initial release
// ============================================================================
module window_skid_fifo
    import window_feeder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = o_valid && i_ready;
    // When full, the slot being written is the one being popped this cycle.
    assign o_ready = (r_count != 2'd2) || w_pop;
    assign w_push  = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : window_feeder
// Summary  : Scans an h x w row-major image and streams each n x n
//            neighbourhood into the rank-order kernel over valid/ready.
// Options  : WINDOW_FEEDER_REPLICATE_PAD_EN - clamp out-of-image taps to the
//            nearest edge pixel and read it, instead of zero padding.
// Revision : 1.0 - initial release
// ============================================================================
module window_feeder
    import window_feeder_pkg::*;
#(
    parameter int WORD       = 32,
    parameter int MAX_N      = 9,
    parameter int INPUT_SIZE = 8,
    parameter int N_BITS     = kernel_n_bits(MAX_N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD-1:0]       h,
    input  logic [WORD-1:0]       w,
    input  logic [N_BITS-1:0]     n,
    output logic                  busy,
    output logic                  done,
    output logic [WORD-1:0]       r_addr,
    output logic                  r_en,
    input  logic [INPUT_SIZE-1:0] r_data,
    output logic [INPUT_SIZE-1:0] pix_out,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  win_last,
    output logic [WORD-1:0]       out_row,
    output logic [WORD-1:0]       out_col
);

    localparam int c_TAP_W = INPUT_SIZE + 1 + 2 * WORD;
    localparam int c_PAD_W = WORD + 1 - N_BITS;

    logic [1:0]        r_state;
    logic [WORD-1:0]   r_h;
    logic [WORD-1:0]   r_w;
    logic [N_BITS-1:0] r_n;
    logic [N_BITS-1:0] r_off;
    logic [WORD-1:0]   r_r;
    logic [WORD-1:0]   r_c;
    logic [N_BITS-1:0] r_dy;
    logic [N_BITS-1:0] r_dx;

    logic              r_pend;
    logic              r_pend_last;
    logic [WORD-1:0]   r_pend_row;
    logic [WORD-1:0]   r_pend_col;

    logic signed [WORD:0] w_y;
    logic signed [WORD:0] w_x;
    logic                 w_y_ok;
    logic                 w_x_ok;
    logic [WORD-1:0]      w_y_rd;
    logic [WORD-1:0]      w_x_rd;
    logic [WORD-1:0]      w_addr;
    logic                 w_pad;

    logic [N_BITS-1:0] w_n_m1;
    logic              w_last_tap;
    logic              w_c_end;
    logic              w_r_end;
    logic              w_degenerate;
    logic              w_credit;
    logic              w_issue;
    logic              w_drained;

    logic               w_push_valid;
    logic [c_TAP_W-1:0] w_push_data;
    logic               w_fifo_ready;
    logic [c_TAP_W-1:0] w_fifo_data;
    logic [1:0]         w_count;

    // Tap coordinates are signed so taps above/left of the image go negative.
    assign w_y = $signed({1'b0, r_r}) + $signed({{c_PAD_W{1'b0}}, r_dy})
               - $signed({{c_PAD_W{1'b0}}, r_off});
    assign w_x = $signed({1'b0, r_c}) + $signed({{c_PAD_W{1'b0}}, r_dx})
               - $signed({{c_PAD_W{1'b0}}, r_off});

    assign w_y_ok = !w_y[WORD] && (w_y[WORD-1:0] < r_h);
    assign w_x_ok = !w_x[WORD] && (w_x[WORD-1:0] < r_w);

`ifdef WINDOW_FEEDER_REPLICATE_PAD_EN
    assign w_y_rd = w_y[WORD] ? '0 : (w_y_ok ? w_y[WORD-1:0] : r_h - WORD'(1));
    assign w_x_rd = w_x[WORD] ? '0 : (w_x_ok ? w_x[WORD-1:0] : r_w - WORD'(1));
    assign w_pad  = 1'b0;
`else
    assign w_y_rd = w_y[WORD-1:0];
    assign w_x_rd = w_x[WORD-1:0];
    assign w_pad  = !(w_y_ok && w_x_ok);
`endif

    assign w_addr = w_y_rd * r_w + w_x_rd;

    assign w_n_m1       = r_n - N_BITS'(1);
    assign w_last_tap   = (r_dx == w_n_m1) && (r_dy == w_n_m1);
    assign w_c_end      = (r_c == r_w - WORD'(1));
    assign w_r_end      = (r_r == r_h - WORD'(1));
    assign w_degenerate = (h == '0) || (w == '0) || (n == '0);

    // An in-flight read already owns a FIFO slot; a padding tap must also wait
    // for it so the two never land in the FIFO out of order.
    assign w_credit = ({1'b0, w_count} + {2'b00, r_pend}) < 3'd2;
    assign w_issue  = (r_state == c_ST_ISSUE) && w_credit
                   && (!w_pad || (!r_pend && w_fifo_ready));

    assign w_drained = !r_pend
                    && ((w_count == 2'd0) || ((w_count == 2'd1) && pix_ready));

    assign r_en   = w_issue && !w_pad;
    assign r_addr = r_en ? w_addr : '0;
    assign busy   = (r_state != c_ST_IDLE);
    assign done   = (r_state == c_ST_DONE);

    assign w_push_valid = r_pend || (w_issue && w_pad);
    assign w_push_data  = r_pend ? {r_data, r_pend_last, r_pend_row, r_pend_col}
                                 : {{INPUT_SIZE{1'b0}}, w_last_tap, r_r, r_c};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_h         <= '0;
            r_w         <= '0;
            r_n         <= '0;
            r_off       <= '0;
            r_r         <= '0;
            r_c         <= '0;
            r_dy        <= '0;
            r_dx        <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_pend_row  <= '0;
            r_pend_col  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_h     <= h;
                        r_w     <= w;
                        r_n     <= n;
                        r_off   <= N_BITS'(kernel_off(32'(n)));
                        r_r     <= '0;
                        r_c     <= '0;
                        r_dy    <= '0;
                        r_dx    <= '0;
                        r_state <= w_degenerate ? c_ST_DONE : c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (w_issue) begin
                        if (r_dx == w_n_m1) begin
                            r_dx <= '0;
                            if (r_dy == w_n_m1) begin
                                r_dy <= '0;
                                if (w_c_end) begin
                                    r_c <= '0;
                                    if (w_r_end) begin
                                        r_state <= c_ST_DRAIN;
                                    end else begin
                                        r_r <= r_r + WORD'(1);
                                    end
                                end else begin
                                    r_c <= r_c + WORD'(1);
                                end
                            end else begin
                                r_dy <= r_dy + N_BITS'(1);
                            end
                        end else begin
                            r_dx <= r_dx + N_BITS'(1);
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_drained) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            r_pend <= r_en;
            if (r_en) begin
                r_pend_last <= w_last_tap;
                r_pend_row  <= r_r;
                r_pend_col  <= r_c;
            end
        end
    end

    window_skid_fifo #(
        .WIDTH (c_TAP_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_push_valid),
        .i_data  (w_push_data),
        .o_ready (w_fifo_ready),
        .o_valid (pix_valid),
        .i_ready (pix_ready),
        .o_data  (w_fifo_data),
        .o_count (w_count)
    );

    assign {pix_out, win_last, out_row, out_col} = w_fifo_data;

endmodule
`default_nettype wire
